axi_wr_burst_sched: RTL and testbench

Write-burst scheduler for the VDMA write path. Accepts one line/frame transfer request (start address, total beats), splits it into AXI INCR bursts of at most `BURST_MAX` beats, optionally never crossing a 4 KB boundary. It issues the bursts one at a time to the single-burst AXI write state core through that core's `write_req`/`req_resp`/`req_done` handshake.

---
 rtl/axi_wr_burst_sched.sv | 175 +++++++++++++++++
 tb/tb_axi_wr_burst_sched.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_burst_sched.sv
// axi_wr_burst_sched: splits one VDMA line/frame write request into AXI INCR
// bursts of at most BURST_MAX beats and hands them one at a time to the
// single-burst AXI write core over its write_req/req_resp/req_done handshake.
//
// Build option: define AXI_WR_4K_SPLIT_EN to additionally cap each burst so
// that it never crosses a 4 KB address boundary.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for xfer_start
// CALC  | end transfer (zero remaining / abort) or size and load next burst
// REQ   | core_req held high until the core acknowledges with core_resp
// WAIT  | burst in flight; core_len/core_addr held until core_done
// NEXT  | advance address, remaining beats and burst count
module axi_wr_burst_sched #(
    parameter int LSIZE      = 10,
    parameter int ASIZE      = 32,
    parameter int TSIZE      = 24,
    parameter int BURST_MAX  = 256,
    parameter int BEAT_BYTES = 32
) (
    input  logic             axi_aclk,
    input  logic             axi_resetn,
    input  logic             xfer_start,
    input  logic [ASIZE-1:0] xfer_addr,
    input  logic [TSIZE-1:0] xfer_beats,
    input  logic             xfer_abort,
    output logic             xfer_busy,
    output logic             xfer_done,
    output logic             xfer_aborted,
    output logic [15:0]      burst_cnt,
    output logic             core_req,
    input  logic             core_resp,
    input  logic             core_done,
    output logic [LSIZE-1:0] core_len,
    output logic [ASIZE-1:0] core_addr
);

    localparam int BB_SHIFT = $clog2(BEAT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_REQ,
        S_WAIT,
        S_NEXT
    } state_t;

    state_t state, state_nxt;

    logic [ASIZE-1:0] cur_addr, cur_addr_d;
    logic [TSIZE-1:0] remain, remain_d;
    logic [LSIZE-1:0] blen, blen_d, blen_w;
    logic             xfer_end;

    logic             busy_d, done_d, aborted_d, req_d;
    logic [LSIZE-1:0] len_d;
    logic [ASIZE-1:0] addr_d;
    logic [15:0]      cnt_d;

`ifdef AXI_WR_4K_SPLIT_EN
    logic [12:0] room_4k;
    logic [12:0] b4k_w;
`endif

    assign xfer_end = (remain == '0) || xfer_abort;

    // Size of the next burst: min(remain, BURST_MAX[, beats left in this 4 KB page])
    always_comb begin
        blen_w = (remain < TSIZE'(BURST_MAX)) ? remain[LSIZE-1:0] : LSIZE'(BURST_MAX);
`ifdef AXI_WR_4K_SPLIT_EN
        room_4k = 13'h1000 - {1'b0, cur_addr[11:0]};
        b4k_w   = room_4k >> BB_SHIFT;
        if (13'(blen_w) > b4k_w) begin
            blen_w = LSIZE'(b4k_w);
        end
`endif
    end

    // State register
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (xfer_start) state_nxt = S_CALC;
            S_CALC: state_nxt = xfer_end ? S_IDLE : S_REQ;
            S_REQ:  if (core_resp) state_nxt = S_WAIT;
            S_WAIT: if (core_done) state_nxt = S_NEXT;
            S_NEXT: state_nxt = S_CALC;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Next values for the registered outputs and datapath
    always_comb begin
        busy_d     = 1'b1;
        done_d     = 1'b0;
        aborted_d  = 1'b0;
        req_d      = core_req;
        len_d      = core_len;
        addr_d     = core_addr;
        cur_addr_d = cur_addr;
        remain_d   = remain;
        blen_d     = blen;
        cnt_d      = burst_cnt;
        case (state)
            S_IDLE: begin
                // busy drops the cycle after xfer_done unless a new start is taken
                busy_d = xfer_start;
                if (xfer_start) begin
                    cur_addr_d = xfer_addr;
                    remain_d   = xfer_beats;
                    cnt_d      = '0;
                end
            end
            S_CALC: begin
                if (xfer_end) begin
                    done_d    = 1'b1;
                    aborted_d = xfer_abort;
                end else begin
                    blen_d = blen_w;
                    len_d  = blen_w;
                    addr_d = cur_addr;
                    req_d  = 1'b1;
                end
            end
            S_REQ: begin
                // the core samples write_req as a level, so drop it right after resp
                if (core_resp) req_d = 1'b0;
            end
            S_NEXT: begin
                cur_addr_d = cur_addr + (ASIZE'(blen) << BB_SHIFT);
                remain_d   = remain - TSIZE'(blen);
                if (burst_cnt != 16'hFFFF) cnt_d = burst_cnt + 16'd1;
            end
            default: ;
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            xfer_busy    <= 1'b0;
            xfer_done    <= 1'b0;
            xfer_aborted <= 1'b0;
            core_req     <= 1'b0;
            core_len     <= '0;
            core_addr    <= '0;
            burst_cnt    <= '0;
            cur_addr     <= '0;
            remain       <= '0;
            blen         <= '0;
        end else begin
            xfer_busy    <= busy_d;
            xfer_done    <= done_d;
            xfer_aborted <= aborted_d;
            core_req     <= req_d;
            core_len     <= len_d;
            core_addr    <= addr_d;
            burst_cnt    <= cnt_d;
            cur_addr     <= cur_addr_d;
            remain       <= remain_d;
            blen         <= blen_d;
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_sched.sv
// Testbench for axi_wr_burst_sched: directed and random transfers against a
// burst-list reference model, with a randomly-delayed core responder.
module tb_axi_wr_burst_sched;

    localparam int LSIZE      = 10;
    localparam int ASIZE      = 32;
    localparam int TSIZE      = 24;
    localparam int BURST_MAX  = 256;
    localparam int BEAT_BYTES = 32;
`ifdef AXI_WR_4K_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    localparam int M_PLAIN   = 0;
    localparam int M_RESTART = 1;
    localparam int M_ABORT   = 2;

    logic             axi_aclk;
    logic             axi_resetn;
    logic             xfer_start;
    logic [ASIZE-1:0] xfer_addr;
    logic [TSIZE-1:0] xfer_beats;
    logic             xfer_abort;
    logic             xfer_busy;
    logic             xfer_done;
    logic             xfer_aborted;
    logic [15:0]      burst_cnt;
    logic             core_req;
    logic             core_resp;
    logic             core_done;
    logic [LSIZE-1:0] core_len;
    logic [ASIZE-1:0] core_addr;

    axi_wr_burst_sched #(
        .LSIZE(LSIZE), .ASIZE(ASIZE), .TSIZE(TSIZE),
        .BURST_MAX(BURST_MAX), .BEAT_BYTES(BEAT_BYTES)
    ) dut (
        .axi_aclk(axi_aclk), .axi_resetn(axi_resetn),
        .xfer_start(xfer_start), .xfer_addr(xfer_addr), .xfer_beats(xfer_beats),
        .xfer_abort(xfer_abort), .xfer_busy(xfer_busy), .xfer_done(xfer_done),
        .xfer_aborted(xfer_aborted), .burst_cnt(burst_cnt),
        .core_req(core_req), .core_resp(core_resp), .core_done(core_done),
        .core_len(core_len), .core_addr(core_addr)
    );

    initial axi_aclk = 1'b0;
    always #5 axi_aclk = ~axi_aclk;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          done_cnt = 0;
    int          req_cyc  = 0;
    bit          core_en;
    int          obs_len[$];
    logic [31:0] obs_addr[$];
    int          exp_len[$];
    logic [31:0] exp_addr[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected burst list from the splitting rules
    task automatic build_exp(input logic [31:0] addr, input int beats);
        logic [31:0] a = addr;
        int r = beats;
        int b;
        int room;
        exp_len.delete();
        exp_addr.delete();
        while (r > 0) begin
            b = (r < BURST_MAX) ? r : BURST_MAX;
            if (SPLIT) begin
                room = (4096 - int'(a % 32'd4096)) / BEAT_BYTES;
                if (room < b) b = room;
            end
            exp_len.push_back(b);
            exp_addr.push_back(a);
            a = a + 32'(b * BEAT_BYTES);
            r = r - b;
        end
    endtask

    // Pulse and activity monitor
    always @(negedge axi_aclk) begin
        if (xfer_done) done_cnt++;
        if (core_req)  req_cyc++;
    end

    // Single-burst core model: random resp and done latencies
    initial begin : core_model
        logic [LSIZE-1:0] l;
        logic [ASIZE-1:0] a;
        core_resp = 1'b0;
        core_done = 1'b0;
        forever begin
            @(posedge axi_aclk); #1;
            if (core_en && axi_resetn && core_req) begin
                repeat ($urandom_range(3, 0)) begin @(posedge axi_aclk); #1; end
                core_resp = 1'b1;
                l = core_len;
                a = core_addr;
                obs_len.push_back(int'(core_len));
                obs_addr.push_back(core_addr);
                @(posedge axi_aclk); #1;
                core_resp = 1'b0;
                chk("req_drop", 64'(core_req), 64'd0);
                repeat ($urandom_range(5, 0)) begin @(posedge axi_aclk); #1; end
                chk("len_hold", 64'(core_len), 64'(l));
                chk("addr_hold", 64'(core_addr), 64'(a));
                core_done = 1'b1;
                @(posedge axi_aclk); #1;
                core_done = 1'b0;
            end
        end
    end

    task automatic run_xfer(input logic [31:0] addr, input int beats, input int mode);
        int obs_base = obs_len.size();
        int d0 = done_cnt;
        int r0 = req_cyc;
        int cyc;
        int n_obs;
        int n_chk;
        build_exp(addr, beats);
        if (mode == M_ABORT) while (exp_len.size() > 1) begin
            void'(exp_len.pop_back());
            void'(exp_addr.pop_back());
        end
        xfer_addr  = addr;
        xfer_beats = TSIZE'(beats);
        xfer_start = 1'b1;
        @(posedge axi_aclk); #1;
        xfer_start = 1'b0;
        chk("busy_t1", 64'(xfer_busy), 64'd1);
        @(posedge axi_aclk); #1;
        cyc = 2;
        if (beats == 0) begin
            chk("zero_done_t2", 64'(xfer_done), 64'd1);
        end else begin
            chk("req_t2", 64'(core_req), 64'd1);
            chk("len_t2", 64'(core_len), 64'(exp_len[0]));
            chk("addr_t2", 64'(core_addr), 64'(exp_addr[0]));
        end
        if (mode != M_PLAIN) begin
            for (int i = 0; i < 50 && !core_resp; i++) @(negedge axi_aclk);
            chk("resp_seen", 64'(core_resp), 64'd1);
            if (mode == M_ABORT) begin
                xfer_abort = 1'b1;
            end else begin
                @(posedge axi_aclk); #1;
                cyc++;
                xfer_addr  = 32'h0000_8000;
                xfer_beats = TSIZE'(5);
                xfer_start = 1'b1;
                @(posedge axi_aclk); #1;
                cyc++;
                xfer_start = 1'b0;
            end
        end
        while (!xfer_done && cyc < 5000) begin
            @(posedge axi_aclk); #1;
            cyc++;
        end
        chk("done_seen", 64'(xfer_done), 64'd1);
        chk("aborted", 64'(xfer_aborted), 64'(mode == M_ABORT));
        chk("burst_cnt", 64'(burst_cnt), 64'(exp_len.size()));
        xfer_abort = 1'b0;
        @(posedge axi_aclk); #1;
        chk("busy_fall", 64'(xfer_busy), 64'd0);
        chk("done_pulse", 64'(xfer_done), 64'd0);
        chk("done_count", 64'(done_cnt - d0), 64'd1);
        if (beats == 0) chk("zero_no_req", 64'(req_cyc - r0), 64'd0);
        n_obs = obs_len.size() - obs_base;
        chk("n_bursts", 64'(n_obs), 64'(exp_len.size()));
        n_chk = (n_obs < exp_len.size()) ? n_obs : exp_len.size();
        for (int i = 0; i < n_chk; i++) begin
            chk("burst_len", 64'(obs_len[obs_base + i]), 64'(exp_len[i]));
            chk("burst_addr", 64'(obs_addr[obs_base + i]), 64'(exp_addr[i]));
        end
        repeat (2) @(posedge axi_aclk);
        #1;
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] ra;
        int          rb;
        axi_resetn = 1'b0;
        xfer_start = 1'b0;
        xfer_addr  = '0;
        xfer_beats = '0;
        xfer_abort = 1'b0;
        core_en    = 1'b1;
        repeat (3) @(posedge axi_aclk);
        #1;
        chk("rst_busy", 64'(xfer_busy), 64'd0);
        chk("rst_done", 64'(xfer_done), 64'd0);
        chk("rst_aborted", 64'(xfer_aborted), 64'd0);
        chk("rst_req", 64'(core_req), 64'd0);
        chk("rst_len", 64'(core_len), 64'd0);
        chk("rst_addr", 64'(core_addr), 64'd0);
        chk("rst_cnt", 64'(burst_cnt), 64'd0);
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
        @(posedge axi_aclk); #1;

        run_xfer(32'h0000_0000, 600, M_PLAIN);
        run_xfer(32'h0000_0F80, 10, M_PLAIN);
        run_xfer(32'h0000_0100, 0, M_PLAIN);
        run_xfer(32'h0000_0000, 600, M_RESTART);
        run_xfer(32'h0000_0000, 600, M_ABORT);

        // reset while the scheduler is holding core_req
        core_en    = 1'b0;
        xfer_addr  = 32'h0000_3000;
        xfer_beats = TSIZE'(16);
        xfer_start = 1'b1;
        @(posedge axi_aclk); #1;
        xfer_start = 1'b0;
        for (int i = 0; i < 10 && !core_req; i++) @(negedge axi_aclk);
        chk("pre_rst_req", 64'(core_req), 64'd1);
        axi_resetn = 1'b0;
        #1;
        chk("mid_rst_req", 64'(core_req), 64'd0);
        chk("mid_rst_busy", 64'(xfer_busy), 64'd0);
        chk("mid_rst_len", 64'(core_len), 64'd0);
        chk("mid_rst_addr", 64'(core_addr), 64'd0);
        @(negedge axi_aclk);
        axi_resetn = 1'b1;
        core_en    = 1'b1;
        @(posedge axi_aclk); #1;
        run_xfer(32'h0000_3000, 16, M_PLAIN);

        for (int k = 0; k < 8; k++) begin
            ra = $urandom & 32'hFFFF_FFE0;
            rb = int'($urandom_range(700, 0));
            run_xfer(ra, rb, M_PLAIN);
        end
        run_xfer(32'hFFFF_FF00, 20, M_PLAIN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
